sap_host_cmd_sequencer: RTL and testbench
=========================================

// Module: sap_host_cmd_sequencer
// PURPOSE
//   Host-side front end of sap_full_system.
//   - Buffers host commands (instruction + data) in a FIFO.
//   - Drives host_instruction/host_data/sap_start for one command at a time.
//   - Waits for sap_operation_done, or times out.
//   - Returns sap_output to the host through a valid/ready response port.
// PARAMETERS
//   INSTR_W        8      width of host_instruction / cmd_instr / rsp_instr
//   DATA_W         256    width of host_data / cmd_data
//   OUT_W          256    width of sap_output / rsp_data
//   CMD_DEPTH      4      command FIFO entries; power of 2, >=2
//   TIMEOUT_CYCLES 65535  max WAIT cycles before a timeout response; >=2
// PORTS
//   clk               in   1                    system clock
//   rst               in   1                    synchronous reset, active-high
//   cmd_valid         in   1                    host command valid
//   cmd_ready         out  1                    FIFO can accept (= !full)
//   cmd_instr         in   INSTR_W              command instruction
//   cmd_data          in   DATA_W               command data
//   cmd_count         out  $clog2(CMD_DEPTH)+1  FIFO occupancy 0..CMD_DEPTH
//   host_instruction  out  INSTR_W              to SAP, registered
//   host_data         out  DATA_W               to SAP, registered
//   sap_start         out  1                    to SAP, one-cycle pulse
//   sap_operation_done in  1                    from SAP
//   sap_output        in   OUT_W                from SAP, valid with done
//   rsp_valid         out  1                    response valid
//   rsp_ready         in   1                    host accepts response
//   rsp_instr         out  INSTR_W              instruction of the completed command
//   rsp_data          out  OUT_W                captured sap_output; 0 on timeout
//   rsp_timeout       out  1                    1 = command timed out
//   busy              out  1                    state != IDLE
// BEHAVIOUR
//   Reset (rst=1 at edge)
//     - FIFO flushed; state=IDLE; timeout counter=0.
//     - All outputs 0, except cmd_ready=1.
//     - Applies mid-operation too: in-flight command and pending response discarded.
//   Command FIFO
//     - Push when cmd_valid&&cmd_ready.
//     - cmd_ready depends only on full: a push is refused when full even on a pop cycle.
//     - Pointers wrap modulo CMD_DEPTH.
//     - Simultaneous push+pop when not full leaves cmd_count unchanged.
//   FSM (IDLE, ISSUE, WAIT, RESP)
//     - IDLE: if FIFO non-empty, pop the head, load host_instruction/host_data, go to ISSUE.
//     - ISSUE: sap_start=1 for exactly this cycle; counter cleared; go to WAIT.
//     - WAIT: counter increments every cycle.
//       - On sap_operation_done=1: rsp_data<=sap_output, rsp_timeout<=0, rsp_valid<=1, go to RESP.
//       - Else, when counter==TIMEOUT_CYCLES-1: rsp_data<=0, rsp_timeout<=1, rsp_valid<=1, go to RESP.
//       - If done and the timeout limit coincide, done wins.
//     - RESP: rsp_* held stable while rsp_valid&&!rsp_ready.
//       - On rsp_ready, clear rsp_valid and go to IDLE.
//       - The next pop is possible at the following edge.
//   Timing and signal rules
//     - sap_operation_done is ignored in IDLE, ISSUE and RESP.
//     - host_instruction/host_data hold from load until the next load; they are not cleared after completion.
//     - Minimum latency: command accepted at edge E -> sap_start high in the cycle between E+1 and E+2.
//     - rsp_instr is latched with host_instruction at pop.
//     - Exactly one sap_start pulse and exactly one response per accepted command; order preserved.
//   Widths
//     - Counter is $clog2(TIMEOUT_CYCLES) bits, saturating compare, no wrap.
// TESTING
//   1. Reset, then push {instr=8'h05, data=256'hA5}.
//      -> sap_start pulse 1 cycle, 2nd cycle after accept; host_instruction=8'h05.
//      -> Model raises done 3 cycles later with sap_output=256'h1234.
//      -> rsp_valid=1, rsp_data=256'h1234, rsp_instr=8'h05, rsp_timeout=0.
//   2. With the SAP stalled, push 5 commands with CMD_DEPTH=4.
//      -> 4 accepted, cmd_count=4, cmd_ready=0; the 5th is held until a pop.
//      -> All 5 responses come back in push order.
//   3. TIMEOUT_CYCLES=16, SAP never asserts done.
//      -> rsp_valid rises 16 cycles after sap_start, with rsp_timeout=1 and rsp_data=0.
//      -> Done asserted on cycle 16 instead -> normal response, rsp_timeout=0.
//   4. Hold rsp_ready=0 for 10 cycles with 2 commands queued.
//      -> rsp_* stable; no second sap_start until the response is taken.
//      -> Stray done pulses during RESP/IDLE cause no effect.
//   5. Assert rst for 1 cycle during WAIT with 3 queued.
//      -> cmd_count=0, rsp_valid=0, busy=0, sap_start never pulses for the flushed commands.

Source files
------------

// File: rtl/sap_host_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sap_host_cmd_sequencer
// Description : Host command front end for the SAP core. Queues commands,
//               issues them one at a time, and returns results or timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module sap_host_cmd_sequencer #(
    parameter int INSTR_W        = 8,
    parameter int DATA_W         = 256,
    parameter int OUT_W          = 256,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [INSTR_W-1:0]             cmd_instr,
    input  logic [DATA_W-1:0]              cmd_data,
    output logic [$clog2(CMD_DEPTH):0]     cmd_count,
    output logic [INSTR_W-1:0]             host_instruction,
    output logic [DATA_W-1:0]              host_data,
    output logic                           sap_start,
    input  logic                           sap_operation_done,
    input  logic [OUT_W-1:0]               sap_output,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [INSTR_W-1:0]             rsp_instr,
    output logic [OUT_W-1:0]               rsp_data,
    output logic                           rsp_timeout,
    output logic                           busy
);

    localparam int c_ptr_w = $clog2(CMD_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES);

    localparam logic [c_cnt_w-1:0] c_full_count = c_cnt_w'(CMD_DEPTH);
    localparam logic [c_tmo_w-1:0] c_tmo_limit  = c_tmo_w'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_resp  = 2'd3;

    // ------------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------------
    logic [INSTR_W-1:0] r_fifo_instr [CMD_DEPTH];
    logic [DATA_W-1:0]  r_fifo_data  [CMD_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic [1:0]         r_state;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    assign w_full  = (r_count == c_full_count);
    assign w_empty = (r_count == '0);
    // Acceptance depends only on full, so a pop in the same cycle never frees a slot early.
    assign w_push  = cmd_valid && !w_full;
    assign w_pop   = (r_state == c_st_idle) && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= cmd_instr;
            r_fifo_data[r_wr_ptr]  <= cmd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Depth is a power of two, so pointer overflow is the wrap.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Issue / wait / respond sequencer
    // ------------------------------------------------------------------------
    logic [INSTR_W-1:0] r_host_instr;
    logic [DATA_W-1:0]  r_host_data;
    logic               r_sap_start;
    logic [c_tmo_w-1:0] r_timer;
    logic               r_rsp_valid;
    logic [INSTR_W-1:0] r_rsp_instr;
    logic [OUT_W-1:0]   r_rsp_data;
    logic               r_rsp_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_host_instr  <= '0;
            r_host_data   <= '0;
            r_sap_start   <= 1'b0;
            r_timer       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_instr   <= '0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (!w_empty) begin
                        r_host_instr <= r_fifo_instr[r_rd_ptr];
                        r_host_data  <= r_fifo_data[r_rd_ptr];
                        r_rsp_instr  <= r_fifo_instr[r_rd_ptr];
                        r_sap_start  <= 1'b1;
                        r_state      <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    r_sap_start <= 1'b0;
                    r_timer     <= '0;
                    r_state     <= c_st_wait;
                end
                c_st_wait: begin
                    // A done that lands on the final timeout cycle still counts as success.
                    if (sap_operation_done) begin
                        r_rsp_data    <= sap_output;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= c_st_resp;
                    end else if (r_timer == c_tmo_limit) begin
                        r_rsp_data    <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= c_st_resp;
                    end else begin
                        r_timer <= r_timer + c_tmo_w'(1);
                    end
                end
                c_st_resp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign cmd_ready        = !w_full;
    assign cmd_count        = r_count;
    assign host_instruction = r_host_instr;
    assign host_data        = r_host_data;
    assign sap_start        = r_sap_start;
    assign rsp_valid        = r_rsp_valid;
    assign rsp_instr        = r_rsp_instr;
    assign rsp_data         = r_rsp_data;
    assign rsp_timeout      = r_rsp_timeout;
    assign busy             = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_sap_host_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sap_host_cmd_sequencer
// Description : Directed bench for sap_host_cmd_sequencer with a small SAP model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sap_host_cmd_sequencer;

    localparam int c_tmo = 16;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [7:0]   cmd_instr;
    logic [255:0] cmd_data;
    logic [2:0]   cmd_count;
    logic [7:0]   host_instruction;
    logic [255:0] host_data;
    logic         sap_start;
    logic         sap_operation_done;
    logic [255:0] sap_output;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [7:0]   rsp_instr;
    logic [255:0] rsp_data;
    logic         rsp_timeout;
    logic         busy;

    sap_host_cmd_sequencer #(
        .INSTR_W        (8),
        .DATA_W         (256),
        .OUT_W          (256),
        .CMD_DEPTH      (4),
        .TIMEOUT_CYCLES (c_tmo)
    ) u_dut (
        .clk                (clk),
        .rst                (rst),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_instr          (cmd_instr),
        .cmd_data           (cmd_data),
        .cmd_count          (cmd_count),
        .host_instruction   (host_instruction),
        .host_data          (host_data),
        .sap_start          (sap_start),
        .sap_operation_done (sap_operation_done),
        .sap_output         (sap_output),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_instr          (rsp_instr),
        .rsp_data           (rsp_data),
        .rsp_timeout        (rsp_timeout),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] sap_fn(input logic [7:0] i);
        return 256'h1234 | (256'(i ^ 8'h05) << 16);
    endfunction

    // SAP model: raises done model_delay cycles after seeing sap_start (0 = never).
    int           model_delay = 0;
    int           m_cnt = 0;
    logic         m_done = 1'b0;
    logic [7:0]   m_instr = '0;
    logic [255:0] m_out = '0;
    logic         stray_done = 1'b0;
    int           start_cnt = 0;

    assign sap_operation_done = m_done | stray_done;
    assign sap_output         = stray_done ? 256'hDEAD : m_out;

    always @(negedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            m_cnt = 0;
        end else if (sap_start) begin
            start_cnt++;
            m_instr = host_instruction;
            m_cnt   = model_delay;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_done = 1'b1;
                m_out  = sap_fn(m_instr);
            end
        end
    end

    typedef struct {
        logic [7:0]   instr;
        logic [255:0] data;
        logic         tmo;
    } rsp_t;
    rsp_t rsp_q[$];

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            rsp_q.push_back('{rsp_instr, rsp_data, rsp_timeout});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] i, input logic [255:0] d);
        int k;
        cmd_valid = 1'b1;
        cmd_instr = i;
        cmd_data  = d;
        k = 0;
        while (!cmd_ready && k < 200) begin
            step();
            k++;
        end
        if (!cmd_ready) chk_eq("push ready bound", 256'(cmd_ready), 256'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!sap_start && n < 200) begin
            step();
            n++;
        end
        if (!sap_start) chk_eq("start bound", 256'(sap_start), 256'd1);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 200) begin
            step();
            n++;
        end
        if (!rsp_valid) chk_eq("rsp bound", 256'(rsp_valid), 256'd1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int n;
        int base;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_instr  = '0;
        cmd_data   = '0;
        rsp_ready  = 1'b0;
        step();
        step();
        chk_eq("rst cmd_ready", 256'(cmd_ready), 256'd1);
        chk_eq("rst cmd_count", 256'(cmd_count), 256'd0);
        chk_eq("rst sap_start", 256'(sap_start), 256'd0);
        chk_eq("rst rsp_valid", 256'(rsp_valid), 256'd0);
        chk_eq("rst busy", 256'(busy), 256'd0);
        chk_eq("rst host_instr", 256'(host_instruction), 256'd0);
        chk_eq("rst rsp_data", rsp_data, 256'd0);
        rst = 1'b0;
        step();

        // 1: single command, done 3 cycles after the start pulse
        model_delay = 3;
        push(8'h05, 256'hA5);
        chk_eq("t1 count after accept", 256'(cmd_count), 256'd1);
        chk_eq("t1 no early start", 256'(sap_start), 256'd0);
        step();
        chk_eq("t1 start", 256'(sap_start), 256'd1);
        chk_eq("t1 host_instr", 256'(host_instruction), 256'h05);
        chk_eq("t1 host_data", host_data, 256'hA5);
        chk_eq("t1 busy", 256'(busy), 256'd1);
        chk_eq("t1 count after pop", 256'(cmd_count), 256'd0);
        step();
        chk_eq("t1 start one cycle", 256'(sap_start), 256'd0);
        wait_rsp(n);
        chk_eq("t1 rsp latency", 256'(n), 256'd3);
        chk_eq("t1 rsp_data", rsp_data, 256'h1234);
        chk_eq("t1 rsp_instr", 256'(rsp_instr), 256'h05);
        chk_eq("t1 rsp_timeout", 256'(rsp_timeout), 256'd0);
        take_rsp();
        chk_eq("t1 rsp cleared", 256'(rsp_valid), 256'd0);
        chk_eq("t1 idle", 256'(busy), 256'd0);
        chk_eq("t1 host_instr held", 256'(host_instruction), 256'h05);

        // 2: FIFO fill while a response is held, then drain in order
        rsp_q.delete();
        base        = start_cnt;
        model_delay = 1;
        push(8'h20, 256'h200);
        wait_rsp(n);
        model_delay = 2;
        for (int i = 1; i <= 4; i++) push(8'h20 + 8'(i), 256'h200 + 256'(i));
        chk_eq("t2 count full", 256'(cmd_count), 256'd4);
        chk_eq("t2 ready low", 256'(cmd_ready), 256'd0);
        cmd_valid = 1'b1;
        cmd_instr = 8'h25;
        cmd_data  = 256'h205;
        for (int i = 0; i < 3; i++) step();
        chk_eq("t2 fifth held", 256'(cmd_count), 256'd4);
        rsp_ready = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        chk_eq("t2 ready after pop", 256'(cmd_ready), 256'd1);
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (rsp_q.size() < 6 && n < 300) begin
            step();
            n++;
        end
        rsp_ready = 1'b0;
        chk_eq("t2 rsp count", 256'(rsp_q.size()), 256'd6);
        chk_eq("t2 start count", 256'(start_cnt - base), 256'd6);
        for (int i = 0; i < 6 && i < rsp_q.size(); i++) begin
            chk_eq($sformatf("t2 rsp%0d instr", i), 256'(rsp_q[i].instr), 256'h20 + 256'(i));
            chk_eq($sformatf("t2 rsp%0d data", i), rsp_q[i].data, sap_fn(8'h20 + 8'(i)));
            chk_eq($sformatf("t2 rsp%0d tmo", i), 256'(rsp_q[i].tmo), 256'd0);
        end
        step();

        // 3: timeout, then done on the very last wait cycle
        model_delay = 0;
        push(8'h30, 256'h300);
        wait_start(n);
        step();
        wait_rsp(n);
        chk_eq("t3 timeout latency", 256'(n), 256'd16);
        chk_eq("t3 timeout flag", 256'(rsp_timeout), 256'd1);
        chk_eq("t3 timeout data", rsp_data, 256'd0);
        chk_eq("t3 timeout instr", 256'(rsp_instr), 256'h30);
        take_rsp();
        model_delay = 16;
        push(8'h31, 256'h310);
        wait_start(n);
        step();
        wait_rsp(n);
        chk_eq("t3 late done latency", 256'(n), 256'd16);
        chk_eq("t3 late done flag", 256'(rsp_timeout), 256'd0);
        chk_eq("t3 late done data", rsp_data, sap_fn(8'h31));
        take_rsp();

        // 4: held response with stray done pulses
        base        = start_cnt;
        model_delay = 2;
        push(8'h41, 256'h410);
        push(8'h42, 256'h420);
        wait_rsp(n);
        for (int k = 0; k < 10; k++) begin
            stray_done = (k == 3 || k == 6);
            step();
            chk_eq("t4 valid held", 256'(rsp_valid), 256'd1);
            chk_eq("t4 instr held", 256'(rsp_instr), 256'h41);
            chk_eq("t4 data held", rsp_data, sap_fn(8'h41));
            chk_eq("t4 no 2nd start", 256'(start_cnt - base), 256'd1);
        end
        stray_done = 1'b0;
        chk_eq("t4 queued", 256'(cmd_count), 256'd1);
        take_rsp();
        wait_rsp(n);
        chk_eq("t4 second instr", 256'(rsp_instr), 256'h42);
        chk_eq("t4 second data", rsp_data, sap_fn(8'h42));
        take_rsp();
        stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        step();
        step();
        chk_eq("t4 idle stray busy", 256'(busy), 256'd0);
        chk_eq("t4 idle stray rsp", 256'(rsp_valid), 256'd0);
        chk_eq("t4 start total", 256'(start_cnt - base), 256'd2);

        // 5: reset during WAIT with three commands queued
        rsp_q.delete();
        model_delay = 0;
        rsp_ready   = 1'b1;
        push(8'h51, 256'h510);
        push(8'h52, 256'h520);
        push(8'h53, 256'h530);
        push(8'h54, 256'h540);
        chk_eq("t5 queued", 256'(cmd_count), 256'd3);
        chk_eq("t5 busy before", 256'(busy), 256'd1);
        base = start_cnt;
        rst  = 1'b1;
        step();
        rst  = 1'b0;
        chk_eq("t5 count", 256'(cmd_count), 256'd0);
        chk_eq("t5 rsp_valid", 256'(rsp_valid), 256'd0);
        chk_eq("t5 busy", 256'(busy), 256'd0);
        chk_eq("t5 cmd_ready", 256'(cmd_ready), 256'd1);
        chk_eq("t5 host_instr", 256'(host_instruction), 256'd0);
        for (int k = 0; k < 20; k++) step();
        chk_eq("t5 no flushed start", 256'(start_cnt - base), 256'd0);
        chk_eq("t5 no response", 256'(rsp_q.size()), 256'd0);
        rsp_ready   = 1'b0;
        model_delay = 1;
        push(8'h77, 256'h770);
        wait_rsp(n);
        chk_eq("t5 recover instr", 256'(rsp_instr), 256'h77);
        chk_eq("t5 recover data", rsp_data, sap_fn(8'h77));
        take_rsp();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
